// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: bus between the PC sequencer, the PC register, instruction memory and decode.
// master: the sequencer (drives pc_next, imem_req, imem_addr, instr_valid, epc, exc_taken, halted).
// slave: the surrounding pipeline (drives pc_cur, imem_ready, stall, redirects, exc, halt_req).
interface pc_seq_ctrl_if;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic        halt_req;
  logic [31:0] epc;
  logic        exc_taken;
  logic        halted;
  modport master (
    input  pc_cur, imem_ready, stall, br_taken, br_target, jump, jump_index, jr, jr_target, exc, halt_req,
    output pc_next, imem_req, imem_addr, instr_valid, epc, exc_taken, halted
  );
  modport slave (
    output pc_cur, imem_ready, stall, br_taken, br_target, jump, jump_index, jr, jr_target, exc, halt_req,
    input  pc_next, imem_req, imem_addr, instr_valid, epc, exc_taken, halted
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC selection and fetch handshake for an enable-less PC register.
// Ports: clk, reset (sync, active-high), bus (pc_seq_ctrl_if.master).
// Optional MIPS delay slot enabled by defining PC_SEQ_DELAY_SLOT_EN.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input logic clk,
  input logic reset,
  pc_seq_ctrl_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0, WAIT = 2'd1, EXEC = 2'd2, HALT = 2'd3;
  logic [1:0]  state, state_nx;
  logic [31:0] seq, tgt, pc_exec, epc_q;
  logic        redir, misal, go, take_exc;
  assign seq   = bus.pc_cur + 32'd4;
  assign redir = bus.jr | bus.jump | bus.br_taken;
  assign tgt   = bus.jr ? bus.jr_target : bus.jump ? {seq[31:28], bus.jump_index, 2'b00} : bus.br_target;
  // only the target that actually wins priority is checked for alignment
  assign misal = (bus.jr | (!bus.jump & bus.br_taken)) & (|tgt[1:0]);
  assign go    = (state == EXEC) & !bus.stall;
`ifdef PC_SEQ_DELAY_SLOT_EN
  logic        pend;
  logic [31:0] pend_pc;
  // the slot instruction's own redirects are ignored, so its targets are never checked
  assign take_exc = go & (bus.exc | (!pend & misal));
  assign pc_exec  = take_exc ? EXC_PC : (bus.halt_req | !pend) ? seq : pend_pc;
  always_ff @(posedge clk)
    if (reset) pend <= 1'b0;
    else if (go) begin
      pend    <= !take_exc & !bus.halt_req & !pend & redir;
      pend_pc <= tgt;
    end
  always_ff @(posedge clk)
    if (reset) epc_q <= 32'd0;
    else if (take_exc) epc_q <= pend ? bus.pc_cur - 32'd4 : bus.pc_cur;
`else
  assign take_exc = go & (bus.exc | misal);
  assign pc_exec  = take_exc ? EXC_PC : (bus.halt_req | !redir) ? seq : tgt;
  always_ff @(posedge clk)
    if (reset) epc_q <= 32'd0;
    else if (take_exc) epc_q <= bus.pc_cur;
`endif
  assign state_nx = (state == FETCH || state == WAIT) ? (bus.imem_ready ? EXEC : WAIT) :
                    (state == EXEC) ? (bus.stall ? EXEC : (!take_exc & bus.halt_req) ? HALT : FETCH) :
                    HALT;
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= state_nx;
  // the PC register has no enable, so holding means re-driving pc_cur
  assign bus.pc_next     = reset ? RESET_PC : go ? pc_exec : bus.pc_cur;
  assign bus.imem_req    = !reset & (state == FETCH || state == WAIT);
  assign bus.imem_addr   = bus.pc_cur;
  assign bus.instr_valid = !reset & (state == EXEC);
  assign bus.exc_taken   = !reset & take_exc;
  assign bus.halted      = !reset & (state == HALT);
  assign bus.epc         = epc_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] exp_epc = 32'd0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        req, iv, et, h;
    logic [31:0] epc;
  } exp_t;
  exp_t q[$];
  pc_seq_ctrl_if bus();
  pc_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) pc_reg <= bus.pc_next;
  assign bus.pc_cur = pc_reg;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (bus.pc_next !== e.npc || bus.imem_req !== e.req || bus.instr_valid !== e.iv ||
            bus.exc_taken !== e.et || bus.halted !== e.h || bus.epc !== e.epc || bus.imem_addr !== pc_reg) begin
          failures++;
          $display("FAIL %s: got pc_next=%h req=%b iv=%b exc_taken=%b halted=%b epc=%h addr=%h want pc_next=%h req=%b iv=%b exc_taken=%b halted=%b epc=%h addr=%h",
                   e.name, bus.pc_next, bus.imem_req, bus.instr_valid, bus.exc_taken, bus.halted, bus.epc, bus.imem_addr,
                   e.npc, e.req, e.iv, e.et, e.h, e.epc, pc_reg);
        end
      end
    end
  end
  task automatic idle();
    reset = 1'b0;
    bus.imem_ready = 1'b1;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 32'd0;
    bus.jump = 1'b0;
    bus.jump_index = 26'd0;
    bus.jr = 1'b0;
    bus.jr_target = 32'd0;
    bus.exc = 1'b0;
    bus.halt_req = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic chk(input string n, input logic [31:0] npc, input logic req, iv, et, h);
    exp_t e;
    e = '{n, npc, req, iv, et, h, exp_epc};
    q.push_back(e);
  endtask
  task automatic fe(input logic [31:0] pc);
    tick();
    chk("fetch", pc, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run(input logic [31:0] pc);
    fe(pc);
    tick();
    chk("seq", pc + 32'd4, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic redir(input string n, input logic [31:0] pc, tgt);
`ifdef PC_SEQ_DELAY_SLOT_EN
    chk(n, pc + 32'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    fe(pc + 32'd4);
    tick();
    chk({n, "_slot"}, tgt, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    chk(n, tgt, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
  endtask
  task automatic do_reset();
    repeat (2) begin
      tick();
      reset = 1'b1;
      chk("reset", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle();
    reset = 1'b1;
    do_reset();
    run(32'h3000);
    run(32'h3004);
    run(32'h3008);
    do_reset();
    run(32'h3000);
    tick(); bus.imem_ready = 1'b0; chk("wait_fetch", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) begin tick(); bus.imem_ready = 1'b0; chk("wait", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0); end
    tick(); chk("wait_ready", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk("exec_after_wait", 32'h3008, 1'b0, 1'b1, 1'b0, 1'b0);
    run(32'h3008);
    run(32'h300c);
    fe(32'h3010);
    tick(); bus.jump = 1'b1; bus.jump_index = 26'h0000C10; redir("jump", 32'h3010, 32'h3040);
    fe(32'h3040);
    tick(); bus.jump = 1'b1; bus.jump_index = 26'h0000C08; bus.br_taken = 1'b1; bus.br_target = 32'h3100;
    redir("jump_over_br", 32'h3040, 32'h3020);
    fe(32'h3020);
    tick(); bus.jr = 1'b1; bus.jr_target = 32'h3002; chk("jr_misalign", 32'h4180, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.exc_taken !== 1'b1 || bus.pc_next !== 32'h4180) begin
      failures++;
      $display("FAIL jr_misalign_direct: exc_taken=%b pc_next=%h", bus.exc_taken, bus.pc_next);
    end
    exp_epc = 32'h3020;
    fe(32'h4180);
    tick(); bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h3200; bus.exc = 1'b1;
    chk("stall_exc", 32'h4180, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      tick(); bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h3200;
      chk("stall", 32'h4180, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick(); bus.br_taken = 1'b1; bus.br_target = 32'h3200; redir("br_after_stall", 32'h4180, 32'h3200);
    fe(32'h3200);
    tick(); bus.jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC; redir("jr", 32'h3200, 32'hFFFF_FFFC);
    fe(32'hFFFF_FFFC);
    tick(); chk("wrap", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(32'h0);
    fe(32'h4);
    tick(); bus.exc = 1'b1; bus.halt_req = 1'b1; chk("exc_over_halt", 32'h4180, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_epc = 32'h4;
    fe(32'h4180);
    tick(); bus.halt_req = 1'b1; chk("halt_req", 32'h4184, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); bus.jump = 1'b1; bus.exc = 1'b1; chk("halted", 32'h4184, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.pc_next !== pc_reg) begin
      failures++;
      $display("FAIL halted_direct: halted=%b pc_next=%h pc_cur=%h", bus.halted, bus.pc_next, pc_reg);
    end
    tick(); chk("halted_hold", 32'h4184, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); reset = 1'b1; chk("reset_halt", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_epc = 32'h0;
    run(32'h3000);
    tick(); bus.imem_ready = 1'b0; chk("fetch_3004", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); bus.imem_ready = 1'b0; chk("wait_3004", 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); reset = 1'b1; chk("reset_wait", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.pc_next !== 32'h3000 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_direct: pc_next=%h req=%b", bus.pc_next, bus.imem_req);
    end
    fe(32'h3000);
`ifdef PC_SEQ_DELAY_SLOT_EN
    tick(); bus.br_taken = 1'b1; bus.br_target = 32'h3100; chk("ds_branch", 32'h3004, 1'b0, 1'b1, 1'b0, 1'b0);
    fe(32'h3004);
    tick(); bus.jump = 1'b1; bus.jump_index = 26'h0000C80; chk("ds_slot", 32'h3100, 1'b0, 1'b1, 1'b0, 1'b0);
    fe(32'h3100);
    tick(); bus.br_taken = 1'b1; bus.br_target = 32'h3200; chk("ds_branch2", 32'h3104, 1'b0, 1'b1, 1'b0, 1'b0);
    fe(32'h3104);
    tick(); bus.exc = 1'b1; chk("ds_slot_exc", 32'h4180, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_epc = 32'h3100;
    run(32'h4180);
`else
    tick(); chk("exec_after_reset", 32'h3004, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
